mips_control_sequencer: RTL and testbench
=========================================

Name: mips_control_sequencer

Overview:
Next-generation multicycle control unit for the MIPS CPU. It owns the instruction state register instead of taking `state` as an input, and skips states the current instruction does not need. It stalls on memory wait-states and on a variable-latency multiply/divide unit, generates byte enables from the address, and counts retired instructions. It sits between the instruction register/address path and the datapath strobes, and replaces the externally sequenced decoder.

Parameters:
COUNT_W, 32, width of retired-instruction counter
MAX_WAIT, 255, max consecutive waitrequest cycles before bus error (used only with optional feature)
WAIT_W, 8, width of wait counter; must hold MAX_WAIT

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
opcode  in  6  instruction [31:26], valid from DECODE onward
func_code  in  6  instruction [5:0]
rt_code  in  5  instruction [20:16]
addr_lo  in  2  ALUOut[1:0], effective address low bits
waitrequest  in  1  memory not ready; current access must be held
muldiv_busy  in  1  mul/div unit computing
pc_is_zero  in  1  PC == 0 (halt condition)
state  out  3  current state encoding
active  out  1  CPU running
IRWrite  out  1  load instruction register
PCWrite  out  1  PC <= PC+4
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IorD  out  1  0 = PC address, 1 = ALUOut address
RegWrite  out  1  register file write
MemtoReg  out  1  1 = write-back from MDR
muldiv_start  out  1  single-cycle start pulse
byteenable  out  4  byte lanes for the current access
instr_count  out  COUNT_W  retired instructions
bus_error  out  1  sticky watchdog error

Behaviour:
- States: FETCH=0, DECODE=1, EXECUTE=2, MEMORY_ACCESS=3, WRITE_BACK=4, HALTED=5. Encodings 6 and 7 go to FETCH on the next clock.
- Reset (asynchronous, any state, mid-access included): state=FETCH; all strobes 0; instr_count=0; bus_error=0; active=0. active=1 from the first clock after reset_n rises until HALTED.
- All strobes are combinational from state, inputs, and the decoded instruction. Registered: state, counters, bus_error.
- FETCH:
  - If pc_is_zero: go to HALTED with no read issued.
  - Otherwise: MemRead=1, IorD=0, byteenable=1111.
  - While waitrequest=1: stay in FETCH with IRWrite=0 and PCWrite=0.
  - On the cycle waitrequest=0: IRWrite=1, PCWrite=1, go to DECODE.
- DECODE: always 1 cycle, then EXECUTE.
- EXECUTE, next state by instruction class:
  - MULT/MULTU/DIV/DIVU: muldiv_start=1 in the first EXECUTE cycle only. Stay in EXECUTE while muldiv_busy=1 (busy is sampled from the cycle after start). Then go to FETCH.
  - LB/LBU/LH/LHU/LW/SB/SH/SW: go to MEMORY_ACCESS.
  - ALU R-type, ALU I-type, LUI, MFHI, MFLO, JAL, JALR, BGEZAL, BLTZAL: go to WRITE_BACK.
  - J, JR, branches, MTHI, MTLO, and unrecognised codes: go to FETCH.
- MEMORY_ACCESS: IorD=1; MemRead=1 for loads, MemWrite=1 for stores. Hold while waitrequest=1. Loads then go to WRITE_BACK; stores go to FETCH.
- byteenable in MEMORY_ACCESS:
  - Word: 1111.
  - Byte: 0001 << addr_lo.
  - Half: addr_lo[1] ? 1100 : 0011.
  - All other states except FETCH: 0000.
- WRITE_BACK: RegWrite=1 for exactly 1 cycle; MemtoReg=1 only for loads. Then go to FETCH.
- instr_count: +1 on every transition into FETCH from a state other than FETCH. Wraps modulo 2^COUNT_W.
- HALTED: terminal until reset; all strobes 0, active=0.
- Simultaneous waitrequest=0 and pc_is_zero do not occur, because the pc_is_zero check precedes the read.

Optional Feature:
BUS_WATCHDOG_EN
- Defined: a wait counter (WAIT_W bits) increments on each FETCH or MEMORY_ACCESS cycle with waitrequest=1 and clears otherwise. When it reaches MAX_WAIT with waitrequest still 1, drop the strobes, go to HALTED next clock, and set bus_error=1 (sticky until reset).
- Undefined: no counter; waitrequest stalls indefinitely; bus_error is tied to 0.

Test Plan:
- Reset then ADDU, no waits -> states 0,1,2,4,0; RegWrite pulses once in state 4; instr_count=1.
- LH with addr_lo=2, waitrequest high 3 cycles in MEMORY_ACCESS -> MemRead held 4 cycles, byteenable=1100, then WRITE_BACK with MemtoReg=1.
- SB with addr_lo=3 -> MemWrite=1, byteenable=1000, return to FETCH with no WRITE_BACK.
- DIV with muldiv_busy high 10 cycles -> muldiv_start pulses once; EXECUTE lasts 11 cycles; instr_count +1.
- pc_is_zero=1 in FETCH -> HALTED, active=0, no MemRead; reset_n low mid-MEMORY_ACCESS -> immediate FETCH, strobes 0.
- BUS_WATCHDOG_EN, MAX_WAIT=4, waitrequest stuck in FETCH -> HALTED with bus_error=1 after the 4th wait cycle.

Source files
------------

// File: rtl/mips_control_sequencer.sv
// mips_control_sequencer: multicycle MIPS control FSM with memory/mul-div stalls, byte enables and a retire counter; BUS_WATCHDOG_EN adds a wait-state watchdog
module mips_control_sequencer #(
    parameter int COUNT_W  = 32,
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func_code,
    input  logic [4:0]         rt_code,
    input  logic [1:0]         addr_lo,
    input  logic               waitrequest,
    input  logic               muldiv_busy,
    input  logic               pc_is_zero,
    output logic [2:0]         state,
    output logic               active,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IorD,
    output logic               RegWrite,
    output logic               MemtoReg,
    output logic               muldiv_start,
    output logic [3:0]         byteenable,
    output logic [COUNT_W-1:0] instr_count,
    output logic               bus_error
);
    typedef enum logic [2:0] {
        FETCH         = 3'd0,
        DECODE        = 3'd1,
        EXECUTE       = 3'd2,
        MEMORY_ACCESS = 3'd3,
        WRITE_BACK    = 3'd4,
        HALTED        = 3'd5
    } state_t;

    state_t state_q, state_d;
    logic   run, in_exec, timeout;
    logic   is_rtype, is_muldiv, is_load, is_store, is_byte, is_half, is_wb;

    if (MAX_WAIT >= 2 ** WAIT_W) begin : g_wait_w_check
        $error("WAIT_W too narrow to hold MAX_WAIT");
    end

    assign is_rtype  = opcode == 6'h00;
    assign is_muldiv = is_rtype && func_code[5:2] == 4'b0110;
    assign is_load   = opcode inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    assign is_store  = opcode inside {6'h28, 6'h29, 6'h2b};
    assign is_byte   = opcode inside {6'h20, 6'h24, 6'h28};
    assign is_half   = opcode inside {6'h21, 6'h25, 6'h29};
    assign is_wb     = (is_rtype && func_code inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                                      6'h09, 6'h10, 6'h12, [6'h20:6'h27], 6'h2a, 6'h2b})
                    || opcode inside {6'h03, [6'h08:6'h0f]}
                    || (opcode == 6'h01 && rt_code[4:1] == 4'b1000);

    assign state  = state_q;
    assign active = run && state_q != HALTED;

    // Next state and strobes; everything stays quiet until the first clock after reset
    always_comb begin
        state_d      = FETCH;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IorD         = 1'b0;
        RegWrite     = 1'b0;
        MemtoReg     = 1'b0;
        muldiv_start = 1'b0;
        byteenable   = 4'b0000;
        if (run) begin
            case (state_q)
                FETCH: begin
                    if (pc_is_zero) begin
                        state_d = HALTED;
                    end else begin
                        MemRead    = 1'b1;
                        byteenable = 4'b1111;
                        IRWrite    = !waitrequest;
                        PCWrite    = !waitrequest;
                        state_d    = waitrequest ? FETCH : DECODE;
                    end
                end
                DECODE: state_d = EXECUTE;
                EXECUTE: begin
                    muldiv_start = is_muldiv && !in_exec;
                    state_d      = is_muldiv ? ((!in_exec || muldiv_busy) ? EXECUTE : FETCH) :
                                   (is_load || is_store) ? MEMORY_ACCESS :
                                   is_wb ? WRITE_BACK : FETCH;
                end
                MEMORY_ACCESS: begin
                    IorD       = 1'b1;
                    MemRead    = is_load;
                    MemWrite   = is_store;
                    byteenable = is_byte ? 4'b0001 << addr_lo :
                                 is_half ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
                    state_d    = waitrequest ? MEMORY_ACCESS : is_load ? WRITE_BACK : FETCH;
                end
                WRITE_BACK: begin
                    RegWrite = 1'b1;
                    MemtoReg = is_load;
                end
                HALTED: state_d = HALTED;
                default: state_d = FETCH;
            endcase
        end
        if (timeout) begin
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            IorD       = 1'b0;
            byteenable = 4'b0000;
            state_d    = HALTED;
        end
    end

    // State register, run flag, first-EXECUTE-cycle tracking and retire counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FETCH;
            run         <= 1'b0;
            in_exec     <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            run     <= 1'b1;
            in_exec <= state_q == EXECUTE;
            if (state_d == FETCH && state_q != FETCH) instr_count <= instr_count + COUNT_W'(1);
        end
    end

`ifdef BUS_WATCHDOG_EN
    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;

    assign waiting = run && waitrequest && ((state_q == FETCH && !pc_is_zero) || state_q == MEMORY_ACCESS);
    assign timeout = waiting && wait_cnt == WAIT_W'(MAX_WAIT - 1);

    // Consecutive wait-state counter and sticky bus error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt  <= '0;
            bus_error <= 1'b0;
        end else begin
            wait_cnt <= waiting ? wait_cnt + WAIT_W'(1) : '0;
            if (timeout) bus_error <= 1'b1;
        end
    end
`else
    assign timeout   = 1'b0;
    assign bus_error = 1'b0;
`endif
endmodule

// File: tb/tb_mips_control_sequencer.sv
// tb_mips_control_sequencer: randomized instruction-phase model checking of mips_control_sequencer
`timescale 1ns/1ps
module tb_mips_control_sequencer;
    localparam int CW = 5;
`ifdef BUS_WATCHDOG_EN
    localparam int MW = 4;
`else
    localparam int MW = 255;
`endif
    localparam logic [7:0] S_IR = 8'h80, S_PC = 8'h40, S_MR = 8'h20, S_MW = 8'h10;
    localparam logic [7:0] S_AD = 8'h08, S_RW = 8'h04, S_MT = 8'h02, S_MS = 8'h01, NONE = 8'h00;
    localparam int K_MD = 0, K_LD = 1, K_ST = 2, K_WB = 3, K_FE = 4;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        bit         fix_fn;
        bit         fix_rt;
        int         kind;
        int         size;
    } ins_t;

    typedef struct {
        int         st;
        logic [7:0] strb;
        logic [3:0] be;
        bit         wr;
        bit         busy;
        bit         ok;
    } cyc_t;

    logic clk = 1'b0, reset_n = 1'b1;
    logic [5:0] opcode = 6'h0, func_code = 6'h0;
    logic [4:0] rt_code = 5'h0;
    logic [1:0] addr_lo = 2'h0;
    logic waitrequest = 1'b0, muldiv_busy = 1'b0, pc_is_zero = 1'b0;
    logic [2:0] state;
    logic active, IRWrite, PCWrite, MemRead, MemWrite, IorD, RegWrite, MemtoReg, muldiv_start, bus_error;
    logic [3:0] byteenable;
    logic [CW-1:0] instr_count;
    logic [7:0] strb;

    int checks = 0, errors = 0, exp_count = 0;
    bit exp_berr = 1'b0;
    ins_t tbl[$];
    cyc_t sched[$];

    mips_control_sequencer #(.COUNT_W(CW), .MAX_WAIT(MW), .WAIT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .func_code(func_code), .rt_code(rt_code),
        .addr_lo(addr_lo), .waitrequest(waitrequest), .muldiv_busy(muldiv_busy), .pc_is_zero(pc_is_zero),
        .state(state), .active(active), .IRWrite(IRWrite), .PCWrite(PCWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .IorD(IorD), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .muldiv_start(muldiv_start), .byteenable(byteenable), .instr_count(instr_count), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    assign strb = {IRWrite, PCWrite, MemRead, MemWrite, IorD, RegWrite, MemtoReg, muldiv_start};

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_cycle(string tag, cyc_t c, bit act);
        check({tag, " state"}, 32'(state), 32'(c.st));
        check({tag, " strobes"}, 32'(strb), 32'(c.strb));
        check({tag, " byteenable"}, 32'(byteenable), 32'(c.be));
        check({tag, " active"}, 32'(active), 32'(act));
        check({tag, " instr_count"}, 32'(instr_count), 32'(exp_count % (1 << CW)));
        check({tag, " bus_error"}, 32'(bus_error), 32'(exp_berr));
    endtask

    function automatic ins_t mk(logic [5:0] op, logic [5:0] fn, logic [4:0] rt, bit ffn, bit frt, int kind, int size);
        ins_t t;
        t.op = op; t.fn = fn; t.rt = rt; t.fix_fn = ffn; t.fix_rt = frt; t.kind = kind; t.size = size;
        return t;
    endfunction

    function automatic void add(int st, logic [7:0] s, logic [3:0] be, bit wr, bit busy, bit ok);
        cyc_t c;
        c.st = st; c.strb = s; c.be = be; c.wr = wr; c.busy = busy; c.ok = ok;
        sched.push_back(c);
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(1));
    endfunction

    task automatic do_reset();
        cyc_t idle;
        idle.st = 0; idle.strb = NONE; idle.be = 4'h0; idle.wr = 1'b0; idle.busy = 1'b0; idle.ok = 1'b0;
        reset_n = 1'b0;
        pc_is_zero = 1'b0;
        waitrequest = 1'b0;
        #1;
        exp_count = 0;
        exp_berr = 1'b0;
        check_cycle("reset", idle, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_cycle("post-reset", idle, 1'b0);
    endtask

    // Expected per-cycle behaviour is built from the instruction class and the chosen stall lengths.
    task automatic run_instr(ins_t in, logic [1:0] alo, int fw, int mw, int bc, bit sb, int abort_at);
        logic [3:0] be;
        logic [7:0] ms;
        logic [5:0] fn;
        logic [4:0] rt;
        string tag;
        fn = in.fix_fn ? in.fn : 6'($urandom);
        rt = in.fix_rt ? in.rt : 5'($urandom);
        tag = $sformatf("op%02h/%02h/%02h", in.op, fn, rt);
        sched.delete();
        repeat (fw) add(0, S_MR, 4'hf, 1'b1, rb(), 1'b0);
        add(0, S_MR | S_IR | S_PC, 4'hf, 1'b0, rb(), 1'b0);
        add(1, NONE, 4'h0, rb(), rb(), 1'b1);
        if (in.kind == K_MD) begin
            add(2, S_MS, 4'h0, rb(), sb, 1'b1);
            repeat (bc) add(2, NONE, 4'h0, rb(), 1'b1, 1'b1);
            add(2, NONE, 4'h0, rb(), 1'b0, 1'b1);
        end else if (in.kind == K_LD || in.kind == K_ST) begin
            be = 4'h0;
            if (in.size == 0) be[alo] = 1'b1;
            else if (in.size == 1) be[{alo[1], 1'b0} +: 2] = 2'b11;
            else be = 4'hf;
            ms = S_AD | (in.kind == K_LD ? S_MR : S_MW);
            add(2, NONE, 4'h0, rb(), rb(), 1'b1);
            repeat (mw) add(3, ms, be, 1'b1, rb(), 1'b1);
            add(3, ms, be, 1'b0, rb(), 1'b1);
            if (in.kind == K_LD) add(4, S_RW | S_MT, 4'h0, rb(), rb(), 1'b1);
        end else begin
            add(2, NONE, 4'h0, rb(), rb(), 1'b1);
            if (in.kind == K_WB) add(4, S_RW, 4'h0, rb(), rb(), 1'b1);
        end
        foreach (sched[i]) begin
            @(negedge clk);
            waitrequest = sched[i].wr;
            muldiv_busy = sched[i].busy;
            opcode    = sched[i].ok ? in.op : 6'($urandom);
            func_code = sched[i].ok ? fn : 6'($urandom);
            rt_code   = sched[i].ok ? rt : 5'($urandom);
            addr_lo   = sched[i].ok ? alo : 2'($urandom);
            #1;
            check_cycle(tag, sched[i], 1'b1);
            if (i == abort_at) begin
                do_reset();
                return;
            end
        end
        exp_count++;
    endtask

    task automatic halt_test();
        cyc_t c;
        c.st = 0; c.strb = NONE; c.be = 4'h0; c.wr = 1'b0; c.busy = 1'b0; c.ok = 1'b0;
        @(negedge clk);
        pc_is_zero = 1'b1;
        waitrequest = 1'b1;
        #1;
        check_cycle("halt-fetch", c, 1'b1);
        c.st = 5;
        repeat (4) begin
            @(negedge clk);
            pc_is_zero = rb();
            waitrequest = rb();
            #1;
            check_cycle("halted", c, 1'b0);
        end
        pc_is_zero = 1'b0;
    endtask

    initial begin
        for (int f = 0; f < 64; f++) begin
            if (f inside {'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h09, 'h10, 'h12, 'h2a, 'h2b} || (f >= 'h20 && f <= 'h27))
                tbl.push_back(mk(6'h00, 6'(f), 5'h0, 1'b1, 1'b0, K_WB, 2));
            else if (f >= 'h18 && f <= 'h1b)
                tbl.push_back(mk(6'h00, 6'(f), 5'h0, 1'b1, 1'b0, K_MD, 2));
            else
                tbl.push_back(mk(6'h00, 6'(f), 5'h0, 1'b1, 1'b0, K_FE, 2));
        end
        for (int o = 1; o < 64; o++) begin
            if (o == 'h01) begin
                tbl.push_back(mk(6'h01, 6'h0, 5'h10, 1'b0, 1'b1, K_WB, 2));
                tbl.push_back(mk(6'h01, 6'h0, 5'h11, 1'b0, 1'b1, K_WB, 2));
                tbl.push_back(mk(6'h01, 6'h0, 5'h00, 1'b0, 1'b1, K_FE, 2));
                tbl.push_back(mk(6'h01, 6'h0, 5'h01, 1'b0, 1'b1, K_FE, 2));
                tbl.push_back(mk(6'h01, 6'h0, 5'h12, 1'b0, 1'b1, K_FE, 2));
            end else if (o == 'h03 || (o >= 'h08 && o <= 'h0f))
                tbl.push_back(mk(6'(o), 6'h0, 5'h0, 1'b0, 1'b0, K_WB, 2));
            else if (o inside {'h20, 'h24})
                tbl.push_back(mk(6'(o), 6'h0, 5'h0, 1'b0, 1'b0, K_LD, 0));
            else if (o inside {'h21, 'h25})
                tbl.push_back(mk(6'(o), 6'h0, 5'h0, 1'b0, 1'b0, K_LD, 1));
            else if (o == 'h23)
                tbl.push_back(mk(6'(o), 6'h0, 5'h0, 1'b0, 1'b0, K_LD, 2));
            else if (o >= 'h28 && o <= 'h2b && o != 'h2a)
                tbl.push_back(mk(6'(o), 6'h0, 5'h0, 1'b0, 1'b0, K_ST, o - 'h28 == 3 ? 2 : o - 'h28));
            else
                tbl.push_back(mk(6'(o), 6'h0, 5'h0, 1'b0, 1'b0, K_FE, 2));
        end

        #2;
        do_reset();
        run_instr(mk(6'h00, 6'h21, 5'h0, 1'b1, 1'b0, K_WB, 2), 2'd0, 0, 0, 0, 1'b0, -1);
        run_instr(mk(6'h21, 6'h0, 5'h0, 1'b0, 1'b0, K_LD, 1), 2'd2, 0, 3, 0, 1'b0, -1);
        run_instr(mk(6'h28, 6'h0, 5'h0, 1'b0, 1'b0, K_ST, 0), 2'd3, 1, 0, 0, 1'b0, -1);
        run_instr(mk(6'h00, 6'h1a, 5'h0, 1'b1, 1'b0, K_MD, 2), 2'd0, 0, 0, 9, 1'b1, -1);
        halt_test();
        do_reset();
        run_instr(mk(6'h23, 6'h0, 5'h0, 1'b0, 1'b0, K_LD, 2), 2'd1, 0, 5, 0, 1'b0, 4);
`ifndef BUS_WATCHDOG_EN
        run_instr(mk(6'h2b, 6'h0, 5'h0, 1'b0, 1'b0, K_ST, 2), 2'd0, 300, 2, 0, 1'b0, -1);
`endif
        for (int n = 0; n < 60; n++)
            run_instr(tbl[$urandom_range(tbl.size() - 1)], 2'($urandom), $urandom_range(3),
                      $urandom_range(3), $urandom_range(5), rb(), -1);
`ifdef BUS_WATCHDOG_EN
        begin
            cyc_t c;
            c.wr = 1'b1; c.busy = 1'b0; c.ok = 1'b0;
            do_reset();
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                waitrequest = 1'b1;
                #1;
                c.st = k <= MW ? 0 : 5;
                c.strb = k < MW ? S_MR : NONE;
                c.be = k < MW ? 4'hf : 4'h0;
                exp_berr = k > MW;
                check_cycle("watchdog", c, k <= MW);
            end
            do_reset();
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
